// File: rtl/mmio_uart_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the MMIO UART responder: register offsets,
// STATUS bit positions and the state encoding common to both serial FSMs.
package mmio_uart_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_RXDATA = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_BAUD   = 2'd3;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_BUSY    = 1;
  localparam int ST_RX_VALID   = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_TX_EMPTY   = 4;

  // Smallest usable divisor: the RX half-bit sample point needs at least 1.
  localparam logic [15:0] MIN_DIV = 16'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic logic [15:0] clamp_div(input logic [15:0] value);
    return (value < MIN_DIV) ? MIN_DIV : value;
  endfunction

endpackage

// File: rtl/mmio_uart_rx.sv
`timescale 1ns/1ps
// UART receiver: input synchronizer, mid-bit sampling FSM and the
// one-byte holding register with its valid/overrun flags.
module mmio_uart_rx
  import mmio_uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic [15:0] baud_div,
  input  logic        pop,
  input  logic        clr_overrun,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        rx_overrun
);

  logic        sync1, sync2, line_prev;
  logic        fall;
  uart_state_t state;
  logic [15:0] cnt;
  logic [15:0] div;
  logic [2:0]  idx;
  logic [7:0]  shift;
  logic        load;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync1     <= rxd;
      sync2     <= sync1;
      line_prev <= sync2;
    end
  end

  assign fall = line_prev & ~sync2;

  // A good stop bit completes the frame.
  assign load = (state == STOP) && (cnt == div) && sync2;

  // Frame FSM; the divisor is re-latched at every sample point so a new
  // BAUDDIV takes effect from the next bit boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      div   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            cnt   <= '0;
            div   <= baud_div;
          end
        end
        START: begin
          if (cnt == (div >> 1)) begin
            cnt <= '0;
            div <= baud_div;
            idx <= '0;
            state <= sync2 ? IDLE : DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == div) begin
            cnt        <= '0;
            div        <= baud_div;
            shift[idx] <= sync2;
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          if (cnt == div) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // Holding register: a completing byte beats a same-cycle pop, and a new
  // overrun beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (load) begin
      rx_byte  <= shift;
      rx_valid <= 1'b1;
      if (rx_valid && !pop) rx_overrun <= 1'b1;
      else if (clr_overrun) rx_overrun <= 1'b0;
    end else begin
      if (pop)         rx_valid   <= 1'b0;
      if (clr_overrun) rx_overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/mmio_uart_responder.sv
`timescale 1ns/1ps
// Memory-mapped UART on the CPU I/O port: register decode, TX FIFO,
// TX serializer, and the RX block instance.
module mmio_uart_responder
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE        = 32'hFFFF_FC00,
  parameter int          TX_DEPTH    = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ioRead,
  input  logic        ioWrite,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        uart_txd,
  input  logic        uart_rxd,
  output logic        irq
);

  localparam int PW = $clog2(TX_DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic        sel;
  logic [1:0]  off;
  logic        wr_tx, wr_status, wr_baud, rd_rx;
  logic [15:0] baud_div;
  logic [7:0]  rx_byte;
  logic        rx_valid, rx_overrun;
  logic [4:0]  status;
  logic        unused_bits;

  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic        tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]  fifo_head;

  uart_state_t tx_state;
  logic [15:0] tx_cnt, tx_div;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_shift;
  logic        bit_done;
  logic        tx_busy;

  assign sel       = (addr[31:4] == BASE[31:4]);
  assign off       = addr[3:2];
  assign wr_tx     = sel && ioWrite && (off == OFF_TXDATA);
  assign wr_status = sel && ioWrite && (off == OFF_STATUS);
  assign wr_baud   = sel && ioWrite && (off == OFF_BAUD);
  assign rd_rx     = sel && ioRead  && (off == OFF_RXDATA);
  assign unused_bits = ^{addr[1:0], din[31:16]};

  // FIFO flags from the extra pointer MSB.
  assign tx_empty  = (wr_ptr == rd_ptr);
  assign tx_full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign fifo_head = fifo_mem[rd_ptr[PW-1:0]];
  // Fullness is judged before any same-cycle pop, so a push while full is lost.
  assign tx_push   = wr_tx && !tx_full;
  assign bit_done  = (tx_cnt == tx_div);
  assign tx_pop    = !tx_empty && ((tx_state == IDLE) || ((tx_state == STOP) && bit_done));
  assign tx_busy   = (tx_state != IDLE);

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (tx_push) fifo_mem[wr_ptr[PW-1:0]] <= din[7:0];
  end

  // FIFO pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (tx_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (tx_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Baud divisor register, clamped so the receiver always has a mid-bit point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         baud_div <= DEFAULT_DIV;
    else if (wr_baud) baud_div <= clamp_div(din[15:0]);
  end

  // TX serializer; STOP chains straight into START when more data waits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_div   <= DEFAULT_DIV;
      tx_idx   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        IDLE: begin
          if (!tx_empty) begin
            tx_state <= START;
            tx_shift <= fifo_head;
            tx_cnt   <= '0;
            tx_div   <= baud_div;
          end
        end
        START: begin
          if (bit_done) begin
            tx_state <= DATA;
            tx_idx   <= '0;
            tx_cnt   <= '0;
            tx_div   <= baud_div;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            tx_cnt <= '0;
            tx_div <= baud_div;
            if (tx_idx == 3'd7) tx_state <= STOP;
            else                tx_idx   <= tx_idx + 3'd1;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: begin
          if (bit_done) begin
            tx_cnt <= '0;
            tx_div <= baud_div;
            if (!tx_empty) begin
              tx_state <= START;
              tx_shift <= fifo_head;
            end else begin
              tx_state <= IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // Line level decoded from state, so reset drives it high without a clock.
  always_comb begin
    uart_txd = 1'b1;
    case (tx_state)
      START:   uart_txd = 1'b0;
      DATA:    uart_txd = tx_shift[tx_idx];
      default: uart_txd = 1'b1;
    endcase
  end

  mmio_uart_rx u_rx (
    .clk         (clk),
    .rst         (rst),
    .rxd         (uart_rxd),
    .baud_div    (baud_div),
    .pop         (rd_rx),
    .clr_overrun (wr_status && din[3]),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_overrun  (rx_overrun)
  );

  assign status[ST_TX_FULL]    = tx_full;
  assign status[ST_TX_BUSY]    = tx_busy;
  assign status[ST_RX_VALID]   = rx_valid;
  assign status[ST_RX_OVERRUN] = rx_overrun;
  assign status[ST_TX_EMPTY]   = tx_empty;

  // Combinational read mux so a load completes in its own cycle.
  always_comb begin
    dout = '0;
    if (sel) begin
      case (off)
        OFF_RXDATA: dout = {24'b0, rx_byte};
        OFF_STATUS: dout = {27'b0, status};
        OFF_BAUD:   dout = {16'b0, baud_div};
        default:    dout = '0;
      endcase
    end
  end

  assign irq = rx_valid | tx_empty;

endmodule

// File: tb/tb_mmio_uart_responder.sv
`timescale 1ns/1ps
// Testbench for mmio_uart_responder: directed register/serial traffic with a
// frame-level reference model compared against txd, irq and load data.
module tb_mmio_uart_responder;

  localparam logic [31:0] A_TX   = 32'hFFFF_FC00;
  localparam logic [31:0] A_RX   = 32'hFFFF_FC04;
  localparam logic [31:0] A_ST   = 32'hFFFF_FC08;
  localparam logic [31:0] A_BAUD = 32'hFFFF_FC0C;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ioRead = 1'b0;
  logic        ioWrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        uart_txd;
  logic        uart_rxd = 1'b1;
  logic        irq;

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  mmio_uart_responder #(
    .BASE        (32'hFFFF_FC00),
    .TX_DEPTH    (DEPTH),
    .DEFAULT_DIV (16'd433)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ioRead   (ioRead),
    .ioWrite  (ioWrite),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .uart_txd (uart_txd),
    .uart_rxd (uart_rxd),
    .irq      (irq)
  );

  // ---------------- reference model ----------------
  logic [7:0]  q[$];
  logic        m_active = 1'b0;
  int          m_k = 0;
  int          m_d = 0;
  int          m_frames = 0;
  logic [7:0]  m_byte = '0;
  logic [15:0] m_baud = 16'd433;
  logic        m_rx_valid = 1'b0;
  logic        m_ovr = 1'b0;
  logic [7:0]  m_rx_byte = '0;
  int          rx_deliver_cnt = 0;
  int          m_seen = 0;
  logic [7:0]  rx_deliver_byte = '0;
  int          m_pre;
  logic        m_sel;
  logic [1:0]  m_off;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_active   = 1'b0;
      m_k        = 0;
      m_d        = 0;
      m_baud     = 16'd433;
      m_rx_valid = 1'b0;
      m_ovr      = 1'b0;
      m_rx_byte  = '0;
      m_seen     = rx_deliver_cnt;
    end else begin
      m_sel = (addr[31:4] == 28'hFFFF_FC0);
      m_off = addr[3:2];
      m_pre = q.size();
      // a frame is 10 bit times; the next queued byte starts without a gap
      if (m_active) begin
        m_k = m_k + 1;
        if (m_k == 10 * (m_d + 1)) m_active = 1'b0;
      end
      if (!m_active && m_pre > 0) begin
        m_byte   = q.pop_front();
        m_active = 1'b1;
        m_k      = 0;
        m_d      = int'(m_baud);
        m_frames = m_frames + 1;
      end
      if (ioWrite && m_sel && m_off == 2'd0 && m_pre < DEPTH) q.push_back(din[7:0]);
      if (ioWrite && m_sel && m_off == 2'd3) m_baud = (din[15:0] < 16'd2) ? 16'd2 : din[15:0];
      if (ioWrite && m_sel && m_off == 2'd2 && din[3]) m_ovr = 1'b0;
      if (ioRead && m_sel && m_off == 2'd1) m_rx_valid = 1'b0;
      if (rx_deliver_cnt != m_seen) begin
        m_seen = rx_deliver_cnt;
        if (m_rx_valid) m_ovr = 1'b1;
        m_rx_byte  = rx_deliver_byte;
        m_rx_valid = 1'b1;
      end
    end
  end

  function automatic logic m_txd();
    int b;
    if (!m_active) return 1'b1;
    b = m_k / (m_d + 1);
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_dout(input logic [31:0] a);
    if (a[31:4] != 28'hFFFF_FC0) return 32'h0;
    case (a[3:2])
      2'd1:    return {24'b0, m_rx_byte};
      2'd2:    return {27'b0, (q.size() == 0), m_ovr, m_rx_valid, m_active, (q.size() == DEPTH)};
      2'd3:    return {16'b0, m_baud};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always begin
    @(negedge clk);
    #2;
    if (rst && cmp_en) begin
      check("txd_model", {31'b0, uart_txd}, {31'b0, m_txd()});
      check("irq_model", {31'b0, irq}, {31'b0, (m_rx_valid || q.size() == 0)});
      if (ioRead) check("dout_model", dout, model_dout(addr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; din = d; ioWrite = 1'b1;
    @(negedge clk);
    ioWrite = 1'b0;
    $display("WR  addr=%h data=%h", a, d);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    addr = a; ioRead = 1'b1;
    #1;
    check(name, dout, exp);
    $display("RD  addr=%h data=%h expect=%h (%s)", a, dout, exp, name);
    @(negedge clk);
    ioRead = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rxd = fr[i];
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (8) @(negedge clk);
    if (stop_bit) begin
      rx_deliver_byte = b;
      rx_deliver_cnt  = rx_deliver_cnt + 1;
    end
    $display("RX  frame byte=%h stop=%0d", b, stop_bit);
  endtask

  initial begin
    logic [9:0] fr;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    cmp_en = 1'b1;
    #1;
    check("txd_reset", {31'b0, uart_txd}, 32'h1);
    check("irq_reset", {31'b0, irq}, 32'h1);
    rd(A_ST, 32'h10, "status_reset");
    rd(A_BAUD, 32'd433, "baud_reset");
    rd(A_TX, 32'h0, "txdata_reads_zero");

    wr(A_BAUD, 32'd1);
    rd(A_BAUD, 32'd2, "baud_clamp");
    wr(A_BAUD, 32'd3);
    rd(32'hFFFF_FC0F, 32'd3, "baud_low_addr_bits");

    // Single frame 0xA5 at 4 clocks/bit, busy throughout
    wr(A_TX, 32'hA5);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      addr = A_ST; ioRead = 1'b1;
      #1;
      check("txd_a5", {31'b0, uart_txd}, {31'b0, fr[i/4]});
      check("busy_a5", {31'b0, dout[1]}, 32'h1);
    end
    @(negedge clk);
    ioRead = 1'b0;
    #1;
    check("txd_after_a5", {31'b0, uart_txd}, 32'h1);
    $display("TX  frame a5 done");

    // Burst of five stores, then one dropped store while full
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      addr = A_TX; din = k; ioWrite = 1'b1;
    end
    @(negedge clk);
    ioWrite = 1'b0; addr = A_ST; ioRead = 1'b1;
    #1;
    check("status_full", dout, 32'h3);
    @(negedge clk);
    ioRead = 1'b0; addr = A_TX; din = 32'h6; ioWrite = 1'b1;
    @(negedge clk);
    ioWrite = 1'b0;
    check("model_queue_full", q.size(), 32'd4);
    $display("TX  burst queued");
    repeat (210) @(negedge clk);
    rd(A_ST, 32'h10, "status_burst_done");
    check("model_frames", m_frames, 32'd6);

    // Receive path
    send_rx(8'h3C, 1'b1);
    rd(A_ST, 32'h14, "status_rx_valid");
    rd(A_RX, 32'h3C, "rxdata_3c");
    rd(A_ST, 32'h10, "status_after_pop");

    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    rd(A_ST, 32'h1C, "status_overrun");
    rd(A_RX, 32'h22, "rxdata_22");
    rd(A_ST, 32'h18, "status_overrun_only");
    wr(A_ST, 32'h8);
    rd(A_ST, 32'h10, "status_overrun_cleared");

    send_rx(8'h55, 1'b0);
    rd(A_ST, 32'h10, "status_framing_error");
    rd(A_RX, 32'h22, "rxdata_kept_on_framing");

    @(negedge clk);
    uart_rxd = 1'b0;
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (50) @(negedge clk);
    rd(A_ST, 32'h10, "status_after_glitch");

    // Reset in the middle of a frame
    wr(A_TX, 32'h00);
    repeat (6) @(negedge clk);
    #1;
    check("txd_mid_frame", {31'b0, uart_txd}, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check("txd_async_reset", {31'b0, uart_txd}, 32'h1);
    check("irq_async_reset", {31'b0, irq}, 32'h1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rd(A_ST, 32'h10, "status_after_reset");
    rd(A_BAUD, 32'd433, "baud_after_reset");

    // Outside the window: nothing decodes
    wr(32'hFFFF_FB00, 32'h41);
    wr(32'hFFFF_FB0C, 32'h5);
    rd(32'hFFFF_FB00, 32'h0, "oow_read_tx");
    rd(32'hFFFF_FB0C, 32'h0, "oow_read_baud");
    rd(A_ST, 32'h10, "oow_status");
    rd(A_BAUD, 32'd433, "oow_baud");
    repeat (20) @(negedge clk);
    check("oow_txd_idle", {31'b0, uart_txd}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_uart_responder.md
Name: mmio_uart_responder

Overview:
- Memory-mapped I/O responder on the CPU's ioRead/ioWrite port: the target side of the load/store path that the core drives through its memory-or-IO unit.
- Decodes a 16-byte register window holding a UART: TX FIFO plus serializer, RX deserializer with one-byte holding register, status, and baud divisor.
- Read data is combinational, so a single-cycle load completes within its cycle.
- All register side effects (FIFO push, RX pop, clears) occur on the rising edge of clk.

Parameters:
- BASE, 32'hFFFF_FC00, window base address; only bits [31:4] are compared.
- TX_DEPTH, 4, TX FIFO entries; must be a power of two and at least 2.
- DEFAULT_DIV, 16'd433, reset value of BAUDDIV; bit period is BAUDDIV+1 clocks.

Ports:
- clk  input  1  system clock, same clock as the CPU.
- rst  input  1  reset, asynchronous, active-low.
- ioRead  input  1  CPU I/O load strobe, valid for one cycle.
- ioWrite  input  1  CPU I/O store strobe, valid for one cycle.
- addr  input  32  byte address, driven from ALUResult.
- din  input  32  store data, driven from rs2Data.
- dout  output  32  load data, combinational.
- uart_txd  output  1  serial out, idles high.
- uart_rxd  input  1  serial in, asynchronous to clk.
- irq  output  1  high when rx_valid is set or the TX FIFO is empty.

Behaviour:
- Select: sel = (addr[31:4] == BASE[31:4]). When sel is 0, dout is 0 and strobes are ignored. Offset is addr[3:2]; addr[1:0] is ignored.
- Off 0x0 TXDATA:
  - Write pushes din[7:0] into the TX FIFO.
  - A push while full is dropped, even if the serializer pops in the same cycle.
  - Read returns 0.
- Off 0x4 RXDATA:
  - Read returns {24'b0, rx_byte}.
  - ioRead clears rx_valid at the clock edge.
  - Write is ignored.
- Off 0x8 STATUS:
  - Read returns {27'b0, tx_empty, rx_overrun, rx_valid, tx_busy, tx_full}.
  - Writing din[3]=1 clears rx_overrun. Other bits are read-only.
- Off 0xC BAUDDIV:
  - Read/write of 16 bits; upper bits read 0.
  - A new value applies from the next bit boundary.
  - Writing a value below 2 is clamped to 2.
- Reset (rst=0, asynchronous):
  - uart_txd=1, FIFO empty, tx state IDLE, rx state IDLE.
  - rx_byte=0, rx_valid=0, rx_overrun=0, BAUDDIV=DEFAULT_DIV, irq=1 (TX FIFO empty).
  - Reset mid-frame aborts the frame immediately; txd returns high asynchronously.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE leaves when the FIFO is non-empty: pop the head and enter START in the same edge.
  - START drives 0 for one bit period.
  - DATA drives 8 bits LSB first, one bit period each, using a 3-bit index.
  - STOP drives 1 for one bit period, then returns to IDLE, or goes straight to START if the FIFO is non-empty (back-to-back frames, no idle gap).
  - tx_busy = (state != IDLE).
  - A per-bit counter counts 0..BAUDDIV and restarts on every state entry.
- RX FSM, states IDLE, START, DATA, STOP:
  - uart_rxd passes through a 2-flop synchronizer.
  - IDLE: a synchronized falling edge enters START.
  - START samples at count (BAUDDIV>>1). If the line is 1, it is a glitch: return to IDLE. If 0, go to DATA.
  - DATA samples 8 bits at full-period spacing from the mid-bit point, LSB first.
  - STOP samples the mid-bit:
    - If 1, load rx_byte and set rx_valid. If rx_valid was already 1 and not popped this cycle, also set rx_overrun.
    - If 0 (framing error), discard the byte with no flag change.
    - Either way, return to IDLE.
- Simultaneous events:
  - Pop of RXDATA in the same cycle as a new byte completes: new byte loaded, rx_valid stays 1, no overrun.
  - Overrun clear in the same cycle as a new overrun: set wins.
- FIFO: read/write pointers are log2(TX_DEPTH)+1 bits wide, with wrap-around using the extra MSB.
  - full = MSBs differ and the rest are equal.
  - empty = pointers equal.

Decomposition:
- Package mmio_uart_pkg:
  - offset constants OFF_TXDATA=2'd0, OFF_RXDATA=2'd1, OFF_STATUS=2'd2, OFF_BAUD=2'd3
  - STATUS bit-index constants
  - shared 2-bit uart_state_t (IDLE, START, DATA, STOP) used by both FSMs
- One sub-module: mmio_uart_rx (synchronizer, RX FSM, rx_byte/valid/overrun). FIFO, TX FSM and register decode stay in the top.

Test Plan:
- Reset, then read 0xFFFFFC08 -> dout=32'h10 (tx_empty=1), uart_txd=1, irq=1. Read 0xFFFFFC0C -> 433.
- Write BAUDDIV=3, then store 0xA5 to TXDATA -> txd shows 0, then 1,0,1,0,0,1,0,1, then 1; each bit lasts 4 clocks, 40 clocks total; tx_busy is high throughout.
- Store 5 bytes 0x01..0x05 back-to-back (TX_DEPTH=4) -> first pops immediately, next 4 are queued and tx_full=1, no byte is dropped. A 6th store while full is dropped. Frames are contiguous with no idle gap.
- Drive rxd with frame 0x3C at 4 clocks/bit -> rx_valid=1, RXDATA reads 0x3C, and the read clears rx_valid.
- Send two frames 0x11 then 0x22 without reading -> RXDATA=0x22, rx_overrun=1. Write STATUS with din=8 -> overrun=0.
- Assert rst mid TX frame -> txd=1 asynchronously, FIFO empty. Access to 0xFFFFFB00 -> dout=0, no state change.
